// File: rtl/data_mem_wait.sv
// Data memory with req/ready/ack handshake, fixed access latency,
// a write-protected boot region and out-of-range rejection.
//
// state | meaning
// IDLE  | ready=1, waiting for req; latches we/addr/wdata on acceptance
// BUSY  | access in flight; cnt counts down, completes when cnt==0
module data_mem_wait #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 128,
    parameter int LATENCY  = 2,
    parameter int WP_LIMIT = 4
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              ack,
    output logic              err,
    output logic [DATA_W-1:0] rdata
);

    localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Limits widened by one bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] WP_L    = (ADDR_W + 1)'(WP_LIMIT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              accept;
    logic              done;
    logic              out_of_range;
    logic              protect_hit;
    logic              good_write;
    logic              good_read;
    logic [IDX_W-1:0]  idx;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    always_comb begin
        state_nxt    = state;
        ready        = 1'b0;
        accept       = 1'b0;
        done         = 1'b0;
        out_of_range = ({1'b0, lat_addr} >= DEPTH_L);
        protect_hit  = lat_we && ({1'b0, lat_addr} < WP_L);
        good_write   = 1'b0;
        good_read    = 1'b0;
        idx          = lat_addr[IDX_W-1:0];
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        good_write = done && !out_of_range && !protect_hit && lat_we;
        good_read  = done && !out_of_range && !lat_we;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            ack       <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
        end else begin
            state <= state_nxt;
            ack   <= done;
            err   <= done && (out_of_range || protect_hit);
            if (accept) begin
                lat_we    <= we;
                lat_addr  <= addr;
                lat_wdata <= wdata;
                cnt       <= CNT_W'(LATENCY - 1);
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (done && out_of_range) begin
                rdata <= '0;
            end else if (good_read) begin
                rdata <= mem[idx];
            end
        end
    end

    // Array is not reset; a reset during BUSY suppresses the pending write.
    always_ff @(posedge ck) begin
        if (!rst && good_write) begin
            mem[idx] <= lat_wdata;
        end
    end

endmodule
